// File: rtl/loop_seq_pkg.sv
// Shared types and constants for the loop sequencer and its dwell timer.
package loop_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DWELL_MIN = 1;

endpackage

// File: rtl/loop_seq_dwell_timer.sv
// Loadable down-counter that measures how long the sequencer holds each value.
module loop_seq_dwell_timer
    import loop_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    input  logic               freeze,
    output logic               expire
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    // The count includes the current cycle, so a count of one marks the final dwell cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !freeze && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q <= DWELL_W'(DWELL_MIN));

endmodule

// File: rtl/loop_sequencer.sv
// Hardware for-loop: steps value from first toward last by step, dwelling on each value.
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode_wrap,
    input  logic [WIDTH-1:0]   cfg_first,
    input  logic [WIDTH-1:0]   cfg_last,
    input  logic [WIDTH-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [WIDTH-1:0]   value,
    output logic               valid,
    output logic               busy,
    output logic               wrap,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH-1:0]   first_q, first_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               wrap_mode_q, wrap_mode_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;

    logic               timer_load;
    logic [DWELL_W-1:0] timer_load_val;
    logic               timer_en;
    logic               timer_expire;

    logic               active;
    logic [WIDTH:0]     next_sum;
    logic               overshoot;
    logic [CNT_W-1:0]   pass_cnt_inc;
    logic [DWELL_W-1:0] cfg_dwell_norm;

    assign active         = (state_q != ST_IDLE);
    // The extra carry bit catches the loop variable wrapping past its width.
    assign next_sum       = {1'b0, value_q} + {1'b0, step_q};
    assign overshoot      = next_sum[WIDTH] || (next_sum[WIDTH-1:0] > last_q);
    assign pass_cnt_inc   = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + 1'b1;
    assign cfg_dwell_norm = (cfg_dwell == '0) ? DWELL_W'(DWELL_MIN) : cfg_dwell;

    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        first_d        = first_q;
        last_d         = last_q;
        step_d         = step_q;
        dwell_d        = dwell_q;
        wrap_mode_d    = wrap_mode_q;
        wrap_d         = 1'b0;
        done_d         = 1'b0;
        pass_cnt_d     = pass_cnt_q;
        timer_load     = 1'b0;
        timer_load_val = dwell_q;
        timer_en       = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            first_d     = cfg_first;
            last_d      = cfg_last;
            step_d      = cfg_step;
            dwell_d     = cfg_dwell_norm;
            wrap_mode_d = mode_wrap;
            pass_cnt_d  = '0;
            if (cfg_first > cfg_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d        = ST_RUN;
                value_d        = cfg_first;
                timer_load     = 1'b1;
                timer_load_val = cfg_dwell_norm;
            end
        end else if (active) begin
            if (pause) begin
                state_d = ST_PAUSE;
            end else begin
                state_d  = ST_RUN;
                timer_en = 1'b1;
                if (timer_expire) begin
                    if (!overshoot) begin
                        value_d    = next_sum[WIDTH-1:0];
                        timer_load = 1'b1;
                    end else if (wrap_mode_q) begin
                        value_d    = first_q;
                        wrap_d     = 1'b1;
                        pass_cnt_d = pass_cnt_inc;
                        timer_load = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        pass_cnt_d = pass_cnt_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            value_q     <= '0;
            first_q     <= '0;
            last_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            wrap_mode_q <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            first_q     <= first_d;
            last_q      <= last_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            wrap_mode_q <= wrap_mode_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    loop_seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .freeze   (pause),
        .expire   (timer_expire)
    );

    assign value    = value_q;
    assign valid    = active;
    assign busy     = active;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Synthesizable, parametrised loop sequencer: a hardware for-loop stepping `value` from `cfg_first` toward `cfg_last` by `cfg_step`, holding each value for `cfg_dwell` clocks. It runs in one-shot or wrap (free-running) mode, with pause, abort and pass counting. An unsized loop variable wrapping past its width never terminates; this block detects that overflow and terminates. Sits in the test/stimulus layer as a clocked stimulus and timebase generator.

## Interface
- `WIDTH`, 4, width of loop variable and config bounds
- `DWELL_W`, 8, width of dwell count
- `CNT_W`, 8, width of completed-pass counter
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; latches config, begins loop
- `stop`  in  1  abort; return to IDLE, no `done`
- `pause`  in  1  level; freezes loop while high
- `mode_wrap`  in  1  0 = one-shot, 1 = reload `cfg_first` after last value
- `cfg_first`, `cfg_last`, `cfg_step`  in  WIDTH  loop bounds/increment, sampled on `start`
- `cfg_dwell`  in  DWELL_W  cycles per value, sampled on `start`; 0 treated as 1
- `value`  out  WIDTH  current loop value
- `valid`  out  1  `value` meaningful
- `busy`  out  1  loop active (RUN or PAUSE)
- `wrap`  out  1  one-cycle pulse on reload to first
- `done`  out  1  one-cycle pulse on one-shot termination
- `pass_cnt`  out  CNT_W  completed passes, saturating

## Operation
- States: IDLE, RUN, PAUSE. Reset → IDLE; all outputs 0.
- Priority each cycle: `reset` > `stop` > `start` > `pause` > normal advance.
- IDLE + `start`: latch config and `mode_wrap`; if `cfg_first > cfg_last` (unsigned), stay IDLE and pulse `done` next cycle, `valid` never set. Otherwise → RUN, `value = cfg_first`, dwell counter loaded, `pass_cnt = 0`.
- RUN: dwell counter decrements; at final dwell cycle compute `next = value + step` in WIDTH+1 bits.
  - `next <= last` and no carry: `value = next`.
  - else (exceeds `last` or carry out): wrap mode → `value = first`, `wrap` pulse, `pass_cnt++` (saturate at all-ones); one-shot → IDLE, `done` pulse, `pass_cnt++`, `valid`/`busy` drop.
- `cfg_step = 0`: legal; value holds `cfg_first` indefinitely until `stop`/`start`/`reset`.
- PAUSE: entered while `pause` high in RUN; dwell counter and `value` frozen, `valid` and `busy` stay 1; back to RUN the cycle after `pause` falls.
- `start` in RUN/PAUSE: restart with newly latched config, `pass_cnt` cleared, no `done`.
- `stop`: → IDLE next cycle, `valid`/`busy` 0, `value` retains last value, no `done`/`wrap`; `pass_cnt` retained.
- Config inputs ignored except at accepted `start`.

## Timing
- `start` sampled at edge t → `value = cfg_first`, `valid = busy = 1` from cycle t+1.
- Each value held exactly max(`cfg_dwell`,1) cycles, excluding paused cycles.
- Step, wrap reload and `done` occur on the edge ending the final dwell cycle; `wrap`/`done` high exactly one cycle coincident with the new `value` / first idle cycle.
- `done` and `wrap` never high simultaneously; `done` never high while `busy`.
- `pause` asserted in cycle c freezes the counter from edge c; N paused cycles lengthen the current dwell by N.

## Structure
- Package `loop_seq_pkg`: state enum typedef (IDLE, RUN, PAUSE), `DWELL_MIN = 1` constant.
- Sub-module `loop_seq_dwell_timer`: loadable down-counter with freeze input and `expire` output; top instantiates one.
- Top holds FSM, config latch, WIDTH+1 adder/compare, pass counter.

## Test plan
- WIDTH=4, first=0, last=5, step=1, dwell=5, one-shot, start at t → values 0..5 each 5 cycles (value 5 at t+26..t+30), `done` at t+31, `pass_cnt=1`.
- Same config, wrap mode → `value=0` with `wrap=1` at t+31, `pass_cnt=2` at t+61; `stop` at t+70 → `busy=0` at t+71, no `done`.
- Overflow: first=0, last=15, step=4, dwell=1, one-shot → values 0,4,8,12 at t+1..t+4, `done` at t+5 (no hang).
- first=7, last=3 → `done` at t+1, `valid` never 1; dwell=0 with first=last=2 → value 2 for one cycle, `done` at t+2.
- Pause high 3 cycles during value 2 (dwell 5) → value 2 held 8 cycles, all later events shifted +3.
- `start` mid-run with first=9 → value 9 next cycle, `pass_cnt=0`; `reset` mid-run → all outputs 0 next cycle.
